apb_master_bridge: RTL and testbench

- Upstream neighbour of the APB memory slave: turns single-beat commands from a simple valid/ready command port into APB setup/access transfers.
- Returns read data and error status on a valid/ready response port.
- One transfer in flight at a time.
- An access-phase wait timeout guarantees forward progress if the slave never asserts Pready.

---
 rtl/apb_master_bridge_if.sv | 41 ++++
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 tb/tb_apb_master_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bus bundle for apb_master_bridge: upstream command/response handshake plus the APB master signals.
// The master modport is the bridge's view; the slave modport is the view of whatever surrounds it.
interface apb_master_bridge_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_slverr;
   logic                  rsp_timeout;

   logic [ADDR_WIDTH-1:0] Paddr;
   logic                  Pselx;
   logic                  Penable;
   logic                  Pwrite;
   logic [DATA_WIDTH-1:0] Pwdata;
   logic                  Pready;
   logic                  Pslverr;
   logic [DATA_WIDTH-1:0] Prdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             Pready, Pslverr, Prdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
             Paddr, Pselx, Penable, Pwrite, Pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             Pready, Pslverr, Prdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
             Paddr, Pselx, Penable, Pwrite, Pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a valid/ready command port to APB setup/access transfers,
// with an access-phase wait timeout and a saturating error counter.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ERRCNT_WIDTH   = 8
) (
   input  logic                    Pclk,
   input  logic                    Prst,
   apb_master_bridge_if.master     bus,
   output logic [ERRCNT_WIDTH-1:0] err_count
);

   localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t                  state, state_nxt;
   logic                    cmd_ready_c, psel_c, penable_c, rsp_valid_c;
   logic                    accept, timeout_hit;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic                    pwrite_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_slverr_q, rsp_timeout_q;
   logic [ERRCNT_WIDTH-1:0] err_cnt_q;
   logic [WCNT_W-1:0]       wait_cnt;

   function automatic logic [ERRCNT_WIDTH-1:0] sat_inc(input logic [ERRCNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + ERRCNT_WIDTH'(1);
   endfunction

   assign accept      = cmd_ready_c & bus.cmd_valid;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_ACCESS) &&
                        !bus.Pready && (wait_cnt == WCNT_LAST);

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (accept) state_nxt = S_SETUP;
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: if (bus.Pready || timeout_hit) state_nxt = S_RESP;
         S_RESP:   if (bus.rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Select/enable/valid decode straight from state so reset drops them at once
   always_comb begin
      cmd_ready_c = 1'b0;
      psel_c      = 1'b0;
      penable_c   = 1'b0;
      rsp_valid_c = 1'b0;
      unique case (state)
         S_IDLE:   cmd_ready_c = Prst;
         S_SETUP:  psel_c      = 1'b1;
         S_ACCESS: begin
            psel_c    = 1'b1;
            penable_c = 1'b1;
         end
         S_RESP:   rsp_valid_c = 1'b1;
         default:  cmd_ready_c = 1'b0;
      endcase
   end

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
         err_cnt_q     <= '0;
         wait_cnt      <= '0;
      end else begin
         if (accept) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
         end
         // Pready wins over a timeout landing on the same edge
         if (state == S_ACCESS) begin
            if (bus.Pready) begin
               rsp_slverr_q  <= bus.Pslverr;
               rsp_rdata_q   <= pwrite_q ? '0 : bus.Prdata;
               rsp_timeout_q <= 1'b0;
               if (bus.Pslverr) err_cnt_q <= sat_inc(err_cnt_q);
            end else if (timeout_hit) begin
               rsp_slverr_q  <= 1'b1;
               rsp_rdata_q   <= '0;
               rsp_timeout_q <= 1'b1;
               err_cnt_q     <= sat_inc(err_cnt_q);
            end else begin
               wait_cnt <= wait_cnt + WCNT_W'(1);
            end
         end
         if (state == S_RESP && bus.rsp_ready) wait_cnt <= '0;
      end
   end

   assign bus.cmd_ready   = cmd_ready_c;
   assign bus.rsp_valid   = rsp_valid_c;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_slverr  = rsp_slverr_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.Paddr       = paddr_q;
   assign bus.Pselx       = psel_c;
   assign bus.Penable     = penable_c;
   assign bus.Pwrite      = pwrite_q;
   assign bus.Pwdata      = pwdata_q;
   assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table of transfers run against a behavioural APB slave,
// responses checked through a scoreboard queue, plus reset-during-access sequence.
module tb_apb_master_bridge;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int EW = 8;

   logic          Pclk = 1'b0;
   logic          Prst = 1'b0;
   logic [EW-1:0] err_count;

   apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .ERRCNT_WIDTH(EW)
   ) dut (
      .Pclk(Pclk), .Prst(Prst), .bus(bus), .err_count(err_count)
   );

   always #5 Pclk = ~Pclk;

   typedef struct {
      bit          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int          waits;    // ACCESS cycles with Pready low; -1 = never ready
      bit          slverr;
      logic [DW-1:0] prdata;
      int          bp;       // cycles rsp_ready held low
      logic [DW-1:0] e_rdata;
      bit          e_slverr;
      bit          e_timeout;
      int          e_acc;    // expected ACCESS (Penable) cycles
   } vec_t;

   typedef struct {
      logic [DW-1:0] rdata;
      bit            slverr;
      bit            timeout;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   cmp_cnt = 0;
   int   fail_cnt = 0;
   int   err_model = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v);
      logic [DW-1:0] pwd_exp;
      int   acc;
      exp_t e;
      exp_t got;
      pwd_exp = v.wr ? v.wdata : '0;
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.Pslverr   = v.slverr;
      bus.Prdata    = v.prdata;
      bus.Pready    = 1'b0;
      @(posedge Pclk); #1;
      e.rdata = v.e_rdata; e.slverr = v.e_slverr; e.timeout = v.e_timeout;
      sb.push_back(e);
      // scramble command lines; they must be ignored outside IDLE
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~v.wr;
      bus.cmd_addr  = ~v.addr;
      bus.cmd_wdata = ~v.wdata;
      chk("setup_pselx",   32'(bus.Pselx), 32'd1);
      chk("setup_penable", 32'(bus.Penable), 32'd0);
      chk("setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("setup_paddr",   32'(bus.Paddr), 32'(v.addr));
      chk("setup_pwrite",  32'(bus.Pwrite), 32'(v.wr));
      chk("setup_pwdata",  bus.Pwdata, pwd_exp);
      @(posedge Pclk); #1;
      acc = 0;
      while (bus.Penable === 1'b1 && acc < 100) begin
         acc++;
         chk("access_paddr", 32'(bus.Paddr), 32'(v.addr));
         bus.Pready = (v.waits >= 0 && acc > v.waits);
         @(posedge Pclk); #1;
      end
      chk("access_cycles", 32'(acc), 32'(v.e_acc));
      bus.Pready = 1'b0;
      chk("rsp_pselx", 32'(bus.Pselx), 32'd0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      for (int i = 0; i < v.bp; i++) begin
         bus.cmd_valid = 1'b1;
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("bp_rdata", bus.rsp_rdata, v.e_rdata);
         @(posedge Pclk); #1;
      end
      bus.cmd_valid = 1'b0;
      got.rdata = bus.rsp_rdata; got.slverr = bus.rsp_slverr; got.timeout = bus.rsp_timeout;
      bus.rsp_ready = 1'b1;
      @(posedge Pclk); #1;
      bus.rsp_ready = 1'b0;
      if (sb.size() == 0) begin
         chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("rsp_rdata",   got.rdata, e.rdata);
         chk("rsp_slverr",  32'(got.slverr), 32'(e.slverr));
         chk("rsp_timeout", 32'(got.timeout), 32'(e.timeout));
      end
      chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      if (v.e_slverr && err_model < 255) err_model++;
      chk("err_count", 32'(err_count), 32'(err_model));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0; bus.Pready = 1'b0; bus.Pslverr = 1'b0; bus.Prdata = '0;

      //          wr addr   wdata          waits slv prdata         bp  e_rdata        e_se e_to acc
      vecs[0] = '{1, 6'd5,  32'hDEADBEEF,  0,    0,  32'h11111111,  0,  32'h0,         0,   0,   1};
      vecs[1] = '{0, 6'd5,  32'h0,         3,    0,  32'hDEADBEEF,  0,  32'hDEADBEEF,  0,   0,   4};
      vecs[2] = '{1, 6'd40, 32'h12345678,  1,    1,  32'h0,         0,  32'h0,         1,   0,   2};
      vecs[3] = '{0, 6'd63, 32'h0,         -1,   0,  32'hA5A5A5A5,  0,  32'h0,         1,   1,   16};
      vecs[4] = '{0, 6'd7,  32'h0,         2,    0,  32'h0BADF00D,  5,  32'h0BADF00D,  0,   0,   3};
      vecs[5] = '{0, 6'd9,  32'h0,         15,   0,  32'h13579BDF,  0,  32'h13579BDF,  0,   0,   16};
      vecs[6] = '{0, 6'd12, 32'h0,         0,    1,  32'hFFFF0000,  0,  32'hFFFF0000,  1,   0,   1};
      vecs[7] = '{1, 6'd33, 32'hCAFEF00D,  -1,   1,  32'h0,         2,  32'h0,         1,   1,   16};

      repeat (3) @(posedge Pclk);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_pselx",     32'(bus.Pselx), 32'd0);
      chk("rst_penable",   32'(bus.Penable), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_paddr",     32'(bus.Paddr), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      Prst = 1'b1;
      @(posedge Pclk); #1;

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // reset asserted while the slave is stalling the access phase
      chk("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 6'd3; bus.Pready = 1'b0;
      @(posedge Pclk); #1;
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge Pclk);
      #1;
      chk("abort_in_access", 32'(bus.Penable), 32'd1);
      #2 Prst = 1'b0;
      #1;
      chk("abort_pselx",     32'(bus.Pselx), 32'd0);
      chk("abort_penable",   32'(bus.Penable), 32'd0);
      chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      err_model = 0;
      chk("abort_err_count", 32'(err_count), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge Pclk); #1;
         chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      Prst = 1'b1;
      @(posedge Pclk); #1;
      chk("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("release_pselx", 32'(bus.Pselx), 32'd0);
      run_txn(vecs[1]);
      run_txn(vecs[2]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end
endmodule
